// File: rtl/cnt_seq_arbiter.sv
// Round-robin arbiter that sequences A/B counting jobs on one shared step counter.
// Optional feature: define CNT_SEQ_ABORT_EN to let abort cut a running job short.
module cnt_seq_arbiter #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] lim_a,
    input  logic             dir_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] lim_b,
    input  logic             dir_b,
    input  logic             abort,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [7:0] PMAX = 8'(TICK_DIV - 1);

    state_t           state, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] target;
    logic [7:0]       presc_q, presc_d;
    logic             dir_q, dir_d;
    logic             own_q, own_d;
    logic             last_q, last_d;
    logic             gnt_a_d, gnt_b_d;
    logic             busy_d, done_d, done_id_d;
    logic             pick_b;
    logic             abort_req;

`ifdef CNT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    // abort is tied off here: every job runs to its target
    assign abort_req = abort & 1'b0;
`endif

    assign target = dir_q ? lim_q : '0;

    // last_q = 1 means B was served last, so A wins a tie
    assign pick_b = req_b & (~req_a | ~last_q);

    always_comb begin
        state_d   = state;
        lim_d     = lim_q;
        dir_d     = dir_q;
        own_d     = own_q;
        last_d    = last_q;
        presc_d   = presc_q;
        cnt_d     = cnt;
        gnt_a_d   = 1'b0;
        gnt_b_d   = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        done_id_d = done_id;

        unique case (state)
            IDLE: begin
                if (req_a | req_b) begin
                    gnt_a_d = ~pick_b;
                    gnt_b_d = pick_b;
                    own_d   = pick_b;
                    lim_d   = pick_b ? lim_b : lim_a;
                    dir_d   = pick_b ? dir_b : dir_a;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort_req) begin
                    done_d    = 1'b1;
                    done_id_d = own_q;
                    state_d   = DONE;
                end else begin
                    cnt_d   = dir_q ? '0 : lim_q;
                    presc_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_req || cnt == target) begin
                    done_d    = 1'b1;
                    done_id_d = own_q;
                    state_d   = DONE;
                end else if (presc_q == PMAX) begin
                    presc_d = '0;
                    cnt_d   = dir_q ? cnt + 1'b1 : cnt - 1'b1;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                last_d  = own_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            presc_q <= '0;
            cnt     <= '0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            state   <= state_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            own_q   <= own_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            cnt     <= cnt_d;
            gnt_a   <= gnt_a_d;
            gnt_b   <= gnt_b_d;
            busy    <= busy_d;
            done    <= done_d;
            done_id <= done_id_d;
        end
    end

endmodule
